// File: rtl/overload_frame_tx_if.sv
// Bus bundle between the interframe-space receiver and the overload frame transmitter.
// Latency: none; this is wiring only.
// Backpressure: none; samplePoint paces every transfer.
// Ports: samplePoint/canRX/isOverload/frameStart flow from the receiver side (master) to
// the transmitter (slave). canTX/overloadActive/endOverload/bitError/overloadCount flow back.
interface overload_frame_tx_if;
  logic       samplePoint;
  logic       canRX;
  logic       isOverload;
  logic       frameStart;
  logic       canTX;
  logic       overloadActive;
  logic       endOverload;
  logic       bitError;
  logic [1:0] overloadCount;

  modport master (
    output samplePoint, canRX, isOverload, frameStart,
    input  canTX, overloadActive, endOverload, bitError, overloadCount
  );

  modport slave (
    input  samplePoint, canRX, isOverload, frameStart,
    output canTX, overloadActive, endOverload, bitError, overloadCount
  );
endinterface

// File: rtl/overload_frame_tx.sv
// CAN overload frame transmitter: dominant flag, wait for recessive, then the delimiter.
// Latency: canTX changes on the same samplePoint edge that sees the request or bus bit.
// Backpressure: none; requests arriving outside IDLE or beyond the consecutive limit are dropped.
// Ports: clock/reset (sync, active-high); bus (slave modport) carries the bit strobe, sampled
// bus level, request and frame-start inputs, and the registered canTX drive plus status pulses.
module overload_frame_tx #(
  parameter int FLAG_LEN      = 6,
  parameter int DELIM_LEN     = 8,
  parameter int MAX_OVERLOADS = 2,
  parameter int MAX_DOM_WAIT  = 8
) (
  input logic                 clock,
  input logic                 reset,
  overload_frame_tx_if.slave  bus
);

  localparam int FLAG_W  = $clog2(FLAG_LEN + 1);
  localparam int DELIM_W = $clog2(DELIM_LEN + 1);
  localparam int DOM_W   = $clog2(MAX_DOM_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLAG       = 2'd1,
    DELIM_WAIT = 2'd2,
    DELIM      = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [FLAG_W-1:0]    flag_cnt_q, flag_cnt_d;
  logic [DELIM_W-1:0]   delim_cnt_q, delim_cnt_d;
  logic [DOM_W-1:0]     dom_cnt_q, dom_cnt_d;
  logic [1:0]           ovl_cnt_q, ovl_cnt_d;
  logic                 can_tx_q, can_tx_d;
  logic                 end_ovl_q, end_ovl_d;
  logic                 bit_err_q, bit_err_d;

  always_comb begin
    state_d     = state_q;
    flag_cnt_d  = flag_cnt_q;
    delim_cnt_d = delim_cnt_q;
    dom_cnt_d   = dom_cnt_q;
    ovl_cnt_d   = ovl_cnt_q;
    can_tx_d    = can_tx_q;
    end_ovl_d   = 1'b0;
    bit_err_d   = 1'b0;

    if (bus.samplePoint) begin
      unique case (state_q)
        IDLE: begin
          if (bus.isOverload && (ovl_cnt_q < 2'(MAX_OVERLOADS))) begin
            state_d    = FLAG;
            can_tx_d   = 1'b0;
            flag_cnt_d = FLAG_W'(1);
          end
        end

        FLAG: begin
          // Reading recessive while we drive dominant means someone else owns the bus.
          if (bus.canRX) begin
            bit_err_d  = 1'b1;
            state_d    = IDLE;
            can_tx_d   = 1'b1;
            flag_cnt_d = '0;
          end else if (flag_cnt_q == FLAG_W'(FLAG_LEN)) begin
            state_d    = DELIM_WAIT;
            can_tx_d   = 1'b1;
            flag_cnt_d = '0;
            dom_cnt_d  = '0;
          end else begin
            flag_cnt_d = flag_cnt_q + FLAG_W'(1);
          end
        end

        DELIM_WAIT: begin
          // Other nodes may still be sending superposed flags; tolerate a bounded run.
          if (bus.canRX) begin
            state_d     = DELIM;
            delim_cnt_d = DELIM_W'(1);
            dom_cnt_d   = '0;
          end else if (dom_cnt_q == DOM_W'(MAX_DOM_WAIT - 1)) begin
            bit_err_d = 1'b1;
            state_d   = IDLE;
            dom_cnt_d = '0;
          end else begin
            dom_cnt_d = dom_cnt_q + DOM_W'(1);
          end
        end

        DELIM: begin
          if (!bus.canRX) begin
            bit_err_d   = 1'b1;
            state_d     = IDLE;
            delim_cnt_d = '0;
          end else if (delim_cnt_q == DELIM_W'(DELIM_LEN - 1)) begin
            end_ovl_d   = 1'b1;
            state_d     = IDLE;
            delim_cnt_d = '0;
            if (ovl_cnt_q < 2'(MAX_OVERLOADS)) begin
              ovl_cnt_d = ovl_cnt_q + 2'd1;
            end
          end else begin
            delim_cnt_d = delim_cnt_q + DELIM_W'(1);
          end
        end

        default: begin
          state_d  = IDLE;
          can_tx_d = 1'b1;
        end
      endcase
    end

    // A new frame start resets the consecutive count, overriding a same-edge increment.
    if (bus.frameStart) begin
      ovl_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      flag_cnt_q  <= '0;
      delim_cnt_q <= '0;
      dom_cnt_q   <= '0;
      ovl_cnt_q   <= '0;
      can_tx_q    <= 1'b1;
      end_ovl_q   <= 1'b0;
      bit_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_cnt_q  <= flag_cnt_d;
      delim_cnt_q <= delim_cnt_d;
      dom_cnt_q   <= dom_cnt_d;
      ovl_cnt_q   <= ovl_cnt_d;
      can_tx_q    <= can_tx_d;
      end_ovl_q   <= end_ovl_d;
      bit_err_q   <= bit_err_d;
    end
  end

  assign bus.canTX          = can_tx_q;
  assign bus.overloadActive = (state_q != IDLE);
  assign bus.endOverload    = end_ovl_q;
  assign bus.bitError       = bit_err_q;
  assign bus.overloadCount  = ovl_cnt_q;

endmodule

// File: doc/overload_frame_tx.md
Name: overload_frame_tx

Overview:
Transmit-side companion to the interframe-space receiver logic. When the receiver flags an overload condition (isOverload), this block drives the CAN overload frame onto canTX: an overload flag of FLAG_LEN dominant bits, then the delimiter. The delimiter is a wait for bus recessive followed by DELIM_LEN recessive bits. On completion it pulses endOverload back to the receiver and counts consecutive overload frames, refusing to exceed MAX_OVERLOADS until a new frame starts.

Parameters:
FLAG_LEN, 6, dominant overload-flag bits transmitted
DELIM_LEN, 8, recessive delimiter bits including the first recessive bit detected
MAX_OVERLOADS, 2, consecutive overload frames allowed between frame starts
MAX_DOM_WAIT, 8, consecutive dominant bits tolerated while waiting for delimiter start

Ports:
clock  in  1  system clock
reset  in  1  reset
samplePoint  in  1  one-clock strobe, once per bit time; all bit-level actions occur only on clock edges with samplePoint=1
canRX  in  1  sampled bus level (1 = recessive)
isOverload  in  1  overload request from interframe-space receiver, sampled at samplePoint
frameStart  in  1  start-of-frame seen; clears consecutive-overload count
canTX  out  1  bus drive (1 = recessive), registered
overloadActive  out  1  high whenever state is not IDLE
endOverload  out  1  one-clock pulse on delimiter completion
bitError  out  1  one-clock pulse on protocol violation; aborts frame
overloadCount  out  2  consecutive overload frames sent, saturating at MAX_OVERLOADS

Behaviour:
- Reset is synchronous and active-high. Values while reset is asserted:
  - state = IDLE
  - canTX = 1
  - overloadActive = 0, endOverload = 0, bitError = 0
  - overloadCount = 0, all internal counters = 0
- Reset asserted mid-frame: canTX returns recessive at the same edge. No endOverload or bitError pulse is generated.
- States: IDLE, FLAG, DELIM_WAIT, DELIM.
- IDLE:
  - On a samplePoint edge with isOverload=1 and overloadCount<MAX_OVERLOADS: go to FLAG, canTX=0 from that edge, flagCnt=1.
  - If overloadCount==MAX_OVERLOADS, isOverload is ignored and canTX stays 1.
- FLAG (canTX=0), at each samplePoint:
  - canRX=1 (drove dominant, read recessive): bitError pulse, go to IDLE, canTX=1.
  - Otherwise, if flagCnt==FLAG_LEN: go to DELIM_WAIT, canTX=1. Else flagCnt++.
  - Net effect: canTX is dominant for exactly FLAG_LEN bit times.
- DELIM_WAIT (canTX=1), at each samplePoint:
  - canRX=1: go to DELIM, delimCnt=1.
  - canRX=0: domCnt++. When domCnt reaches MAX_DOM_WAIT: bitError pulse, go to IDLE.
- DELIM (canTX=1), at each samplePoint:
  - canRX=0: bitError pulse, go to IDLE.
  - Otherwise, if delimCnt==DELIM_LEN-1: endOverload pulse, go to IDLE, overloadCount++ (saturating at MAX_OVERLOADS). Else delimCnt++.
  - Net effect: DELIM_LEN recessive bits in total, counting the bit that ended DELIM_WAIT.
- endOverload and bitError are each high for exactly one clock and are never high together.
- frameStart=1 on any clock clears overloadCount to 0. If it coincides with an increment, the clear wins. frameStart does not change the state.
- isOverload outside IDLE is ignored. A new overload frame needs isOverload seen in IDLE at a later samplePoint.
- Non-samplePoint clocks hold all state, counters and canTX; pulse outputs are 0 on those clocks.
- Counters are sized for their parameter maximum, with no wrap-around.

Test Plan:
- Idle bus: canRX=1, isOverload=0 for 20 samplePoints -> canTX=1, overloadActive=0, no pulses.
- Nominal frame: isOverload=1 at one samplePoint, canRX mirrors canTX -> canTX=0 for 6 samplePoints, then 1; endOverload pulses at the 8th recessive samplePoint; overloadCount=1.
- Superposed flags: after our 6-bit flag, canRX stays 0 for 3 more samplePoints, then 1 -> endOverload after 8 recessive samplePoints; no bitError. With 8 dominant samplePoints instead -> bitError pulse, IDLE, overloadCount unchanged.
- Flag and delimiter violations:
  - canRX=1 at the 3rd flag bit -> bitError pulse, canTX=1 at the same edge.
  - canRX=0 at the 5th delimiter bit -> bitError pulse, no endOverload.
- Saturation: three back-to-back requests without frameStart -> two frames sent, overloadCount=2, third request ignored (canTX stays 1). Then frameStart=1 -> overloadCount=0 and the next request is accepted.
- Reset mid-FLAG at the 4th bit -> canTX=1 and state IDLE from that edge, no pulses; a request after reset produces a full 6-bit flag.
